// File: rtl/manchester_receiver.sv
// Manchester receiver: recovers bits from an oversampled line, frames on SYNC_WORD, 4-cycle latency to m_tvalid.
// Holds a word until m_tready (a word arriving meanwhile is dropped and sets overrun); MANCH_RX_PARITY_EN adds an even-parity bit per word.
module manchester_receiver #(
  parameter int         OVERSAMPLE = 8,
  parameter int         DATA_W     = 8,
  parameter logic [7:0] SYNC_WORD  = 8'hD5
) (
  input  logic              clk108,
  input  logic              sys_rst_n,
  input  logic              serial_in,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              frame_active,
  output logic              code_err,
  output logic              overrun
);
  localparam int CNT_W = $clog2(2*OVERSAMPLE) + 1;
  localparam logic [CNT_W:0] MID_LO = (CNT_W+1)'(3*OVERSAMPLE/4);
  localparam logic [CNT_W:0] MID_HI = (CNT_W+1)'(5*OVERSAMPLE/4);
`ifdef MANCH_RX_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int BC_W = $clog2(FRAME_BITS + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(FRAME_BITS - 1);
`ifdef MANCH_RX_PARITY_EN
  localparam logic [BC_W-1:0] PAR_BIT = BC_W'(DATA_W);
`endif

  typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;
  state_t state, state_nxt;

  logic              sync1, sync2, sync_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    elapsed;
  logic [BC_W-1:0]   bitcnt;
  logic [7:0]        sync_sr, sync_nxt;
  logic [DATA_W-1:0] word_sr;
  logic              edge_det, mid_edge, carrier_loss, par_ok;
  logic              take_edge, hunt_shift, word_shift, word_last, word_done_nxt, err_nxt;
  logic              word_done;

  always_ff @(posedge clk108 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= serial_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  // elapsed counts the edge cycle itself, so a sender period of N cycles is seen as N
  assign edge_det     = sync2 ^ sync_d;
  assign elapsed      = {1'b0, cnt} + (CNT_W+1)'(1);
  assign mid_edge     = edge_det && (elapsed >= MID_LO) && (elapsed <= MID_HI);
  assign carrier_loss = elapsed > MID_HI;
  assign sync_nxt     = {sync_sr[6:0], sync2};

`ifdef MANCH_RX_PARITY_EN
  assign par_ok = ~((^word_sr) ^ sync2);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk108 or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (edge_det) state_nxt = HUNT;
      HUNT: begin
        if (carrier_loss)                             state_nxt = IDLE;
        else if (mid_edge && sync_nxt == SYNC_WORD)   state_nxt = DATA;
      end
      DATA: if (carrier_loss) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    take_edge     = 1'b0;
    hunt_shift    = 1'b0;
    word_shift    = 1'b0;
    word_last     = 1'b0;
    word_done_nxt = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      IDLE: take_edge = edge_det;
      HUNT: begin
        take_edge  = mid_edge;
        hunt_shift = mid_edge;
      end
      DATA: begin
        take_edge = mid_edge;
        word_last = mid_edge && (bitcnt == LAST_BIT);
`ifdef MANCH_RX_PARITY_EN
        word_shift = mid_edge && (bitcnt != PAR_BIT);
`else
        word_shift = mid_edge;
`endif
        word_done_nxt = word_last && par_ok;
        err_nxt       = (carrier_loss && bitcnt != '0) || (word_last && !par_ok);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk108 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt          <= '0;
      bitcnt       <= '0;
      sync_sr      <= '0;
      word_sr      <= '0;
      word_done    <= 1'b0;
      code_err     <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      if (take_edge)       cnt <= '0;
      else if (cnt != '1)  cnt <= cnt + CNT_W'(1);
      if (state == IDLE && edge_det) sync_sr <= '0;
      else if (hunt_shift)           sync_sr <= sync_nxt;
      if (word_shift) word_sr <= {word_sr[DATA_W-2:0], sync2};
      if (state != DATA || state_nxt != DATA) bitcnt <= '0;
      else if (mid_edge)                       bitcnt <= word_last ? '0 : bitcnt + BC_W'(1);
      word_done    <= word_done_nxt;
      code_err     <= err_nxt;
      frame_active <= (state == DATA);
    end
  end

  always_ff @(posedge clk108 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      overrun  <= 1'b0;
    end else if (word_done) begin
      if (m_tvalid && !m_tready) begin
        overrun <= 1'b1;
      end else begin
        m_tdata  <= word_sr;
        m_tvalid <= 1'b1;
      end
    end else if (m_tvalid && m_tready) begin
      m_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_manchester_receiver.sv
// Bench for manchester_receiver: table of framed transfers plus hand-written backpressure, reset and parity sequences.
`timescale 1ns/1ps
module tb_manchester_receiver;
  logic       clk108    = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       serial_in = 1'b0;
  logic       m_tready  = 1'b1;
  logic [7:0] m_tdata;
  logic       m_tvalid, frame_active, code_err, overrun;

  manchester_receiver #(.OVERSAMPLE(8), .DATA_W(8), .SYNC_WORD(8'hD5)) dut (
    .clk108(clk108), .sys_rst_n(sys_rst_n), .serial_in(serial_in),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .frame_active(frame_active), .code_err(code_err), .overrun(overrun)
  );

  always #5 clk108 = ~clk108;

  int cyc = 0;
  always @(posedge clk108) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int mid; bit chk; } exp_t;
  typedef struct { int per; int nw; logic [7:0] w0; logic [7:0] w1; int tail; bit dec; int errs; } vec_t;

  exp_t exp_q[$];
  exp_t e;
  vec_t vecs[6];
  int   tests = 0, fails = 0;
  int   err_pulses = 0, err_cyc = 0, last_mid = 0, base = 0, tail_mid = 0;
  bit   lat_on = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin @(posedge clk108); #1; end
  endtask

  // first half carries the inverse level so the mid-bit transition encodes the bit
  task automatic send_bit(input logic b, input int per);
    serial_in = ~b;
    hold((per + 1) / 2);
    serial_in = b;
    last_mid  = cyc;
    hold(per / 2);
  endtask

  task automatic send_raw(input logic [7:0] v, input int n, input int per);
    logic [7:0] t;
    t = v;
    for (int i = n - 1; i >= 0; i--) send_bit(t[i], per);
  endtask

  task automatic send_preamble(input int per);
    send_raw(8'h55, 8, per);
    send_raw(8'h55, 8, per);
    send_raw(8'hD5, 8, per);
  endtask

  task automatic send_word(input logic [7:0] w, input int per, input bit push, input logic bad_par);
    for (int i = 7; i >= 0; i--) begin
`ifndef MANCH_RX_PARITY_EN
      if (i == 0 && push && !bad_par) exp_q.push_back('{w, cyc + (per + 1) / 2, lat_on});
`endif
      send_bit(w[i], per);
    end
`ifdef MANCH_RX_PARITY_EN
    if (push && !bad_par) exp_q.push_back('{w, cyc + (per + 1) / 2, lat_on});
    send_bit((^w) ^ bad_par, per);
`endif
  endtask

  initial begin
    vecs[0] = '{8,  2, 8'hA3, 8'h3C, 0, 1'b1, 0};
    vecs[1] = '{8,  1, 8'hA3, 8'h00, 4, 1'b1, 1};
    vecs[2] = '{7,  1, 8'hA3, 8'h00, 0, 1'b1, 0};
    vecs[3] = '{9,  1, 8'hA3, 8'h00, 0, 1'b1, 0};
    vecs[4] = '{11, 1, 8'hA3, 8'h00, 0, 1'b0, 0};
    vecs[5] = '{8,  2, 8'hFF, 8'h00, 0, 1'b1, 0};

    fork
      forever begin
        @(negedge clk108);
        if (sys_rst_n) begin
          if (code_err) begin
            err_pulses++;
            err_cyc = cyc;
          end
          if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected word: got %0h, expected none", m_tdata);
            end else begin
              e = exp_q.pop_front();
              check("word data", m_tdata, e.data);
              if (e.chk) begin
                check("word latency", cyc - e.mid, 4);
                check("frame_active at word", frame_active, 1);
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk108);
    #1;
    check("reset m_tvalid", m_tvalid, 0);
    check("reset m_tdata", m_tdata, 0);
    check("reset frame_active", frame_active, 0);
    check("reset code_err", code_err, 0);
    check("reset overrun", overrun, 0);
    sys_rst_n = 1'b1;
    hold(5);

    for (int v = 0; v < 6; v++) begin
      base = err_pulses;
      send_preamble(vecs[v].per);
      if (vecs[v].nw > 0) send_word(vecs[v].w0, vecs[v].per, vecs[v].dec, 1'b0);
      if (vecs[v].nw > 1) send_word(vecs[v].w1, vecs[v].per, vecs[v].dec, 1'b0);
      if (vecs[v].tail > 0) send_raw(8'h0A, vecs[v].tail, vecs[v].per);
      tail_mid = last_mid;
      hold(60);
      check($sformatf("v%0d words outstanding", v), exp_q.size(), 0);
      exp_q.delete();
      check($sformatf("v%0d code_err pulses", v), err_pulses - base, vecs[v].errs);
      if (vecs[v].errs != 0) check($sformatf("v%0d code_err timing", v), err_cyc - tail_mid, 14);
      check($sformatf("v%0d frame_active idle", v), frame_active, 0);
      check($sformatf("v%0d m_tvalid idle", v), m_tvalid, 0);
      check($sformatf("v%0d overrun", v), overrun, 0);
    end

    // consumer stalled for the whole frame: first word held, second dropped
    base = err_pulses;
    m_tready = 1'b0;
    lat_on = 1'b0;
    send_preamble(8);
    send_word(8'hA3, 8, 1'b1, 1'b0);
    send_word(8'h3C, 8, 1'b0, 1'b0);
    hold(60);
    check("stall m_tvalid held", m_tvalid, 1);
    check("stall m_tdata held", m_tdata, 8'hA3);
    check("stall overrun", overrun, 1);
    check("stall code_err pulses", err_pulses - base, 0);
    m_tready = 1'b1;
    hold(1);
    m_tready = 1'b0;
    check("m_tvalid clears after accept", m_tvalid, 0);
    check("stall words outstanding", exp_q.size(), 0);
    exp_q.delete();

    // reset in the middle of a data word
    base = err_pulses;
    send_preamble(8);
    send_word(8'hA3, 8, 1'b0, 1'b0);
    send_raw(8'h03, 4, 8);
    check("pre-reset m_tvalid", m_tvalid, 1);
    check("pre-reset frame_active", frame_active, 1);
    sys_rst_n = 1'b0;
    #1;
    check("mid-frame reset m_tvalid", m_tvalid, 0);
    check("mid-frame reset m_tdata", m_tdata, 0);
    check("mid-frame reset frame_active", frame_active, 0);
    check("mid-frame reset code_err", code_err, 0);
    check("mid-frame reset overrun", overrun, 0);
    hold(3);
    sys_rst_n = 1'b1;
    m_tready = 1'b1;
    lat_on = 1'b1;
    send_raw(8'h0C, 4, 8);
    send_preamble(8);
    send_word(8'h5A, 8, 1'b1, 1'b0);
    hold(60);
    check("post-reset words outstanding", exp_q.size(), 0);
    exp_q.delete();
    check("post-reset code_err pulses", err_pulses - base, 0);
    check("post-reset overrun", overrun, 0);

`ifdef MANCH_RX_PARITY_EN
    base = err_pulses;
    send_preamble(8);
    send_word(8'hA3, 8, 1'b1, 1'b0);
    hold(60);
    check("parity good words outstanding", exp_q.size(), 0);
    exp_q.delete();
    check("parity good code_err pulses", err_pulses - base, 0);
    base = err_pulses;
    send_preamble(8);
    send_word(8'hA3, 8, 1'b1, 1'b1);
    send_word(8'h3C, 8, 1'b1, 1'b0);
    hold(60);
    check("parity bad words outstanding", exp_q.size(), 0);
    exp_q.delete();
    check("parity bad code_err pulses", err_pulses - base, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
